// File: rtl/wide_add_pkg.sv
// Shared constants and types for the wide add/subtract sequencer.
package wide_add_pkg;

    localparam int unsigned SLICE_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Beat counter width; one bit minimum so a single-beat build still has a counter.
    function automatic int unsigned beat_cnt_w(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;

    // Bit and group generate/propagate, then per-group lookahead carries.
    always_comb begin
        g  = a_i & b_i;
        p  = a_i ^ b_i;
        c  = '0;
        gg = '0;
        gp = '0;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        c[0] = cin_i;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
        end
    end

    assign sum_o  = p ^ c[31:0];
    assign cout_o = c[32];

endmodule

// File: rtl/wide_add_seq.sv
// WIDTH-bit add (optional subtract) built by stepping one cla32 over WIDTH/32 beats,
// low slice first, with the carry held in a register between beats.
// Optional feature macro: WIDE_ADD_SUB_EN (honour in_sub: invert B, force carry-in to 1).
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned BEATS     = WIDTH / SLICE_W;
    localparam int unsigned CNT_W     = beat_cnt_w(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   beat_q, beat_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic [SLICE_W-1:0] cla_sum;
    logic               cla_cout;

`ifdef WIDE_ADD_SUB_EN
    // Subtract as A + ~B + 1; in_cin has no meaning for a subtract.
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub ? 1'b1 : in_cin;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign b_eff      = in_b;
    assign cin_eff    = in_cin;
`endif

    // Single shared slice adder, fed from the low end of the operand shifters.
    cla32 u_cla (
        .a_i    (a_q[SLICE_W-1:0]),
        .b_i    (b_q[SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (cla_sum),
        .cout_o (cla_cout)
    );

    // Handshake flags depend only on the current state.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_sum   = res_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

    // Next-state: latch on accept, one slice per RUN cycle, hold result until consumed.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        beat_d  = beat_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    beat_d  = '0;
                    a_msb_d = in_a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                res_d   = res_q >> SLICE_W;
                res_d[WIDTH-1 -: SLICE_W] = cla_sum;
                carry_d = cla_cout;
                beat_d  = beat_q + CNT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    cout_d  = cla_cout;
                    ovf_d   = (a_msb_q == b_msb_q) & (cla_sum[SLICE_W-1] != a_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            beat_q  <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            beat_q  <= beat_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle sequencer computing WIDTH-bit add (optionally subtract) by time-multiplexing one 32-bit carry-lookahead adder (cla32) over WIDTH/32 beats, low slice first, carry registered between beats. Sits between the execute stage and any wide-arithmetic consumer (multi-word ALU ops, address/accumulator extension). Valid/ready on both sides; one operation in flight.

## Interface
- WIDTH, 128, operand/result width; multiple of 32, ≥32
- BEATS, WIDTH/32 (localparam), slices per operation
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in (add only)
- in_sub  in  1  1 = A−B; ignored without macro
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of bit WIDTH−1
- out_ovf  out  1  signed overflow
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid: latch A, B_eff (B, or ~B if sub), carry_reg = in_cin (1 if sub), beat=0, save MSBs of A and B_eff; → RUN.
- RUN: cla32 fed A[31:0], B_eff[31:0], carry_reg; A/B shift right 32; sum slice shifted into top of result reg; carry_reg ← cout; beat++. After beat BEATS−1 → DONE.
- DONE: out_valid=1; out_sum/out_cout/out_ovf stable until out_valid&out_ready; then → IDLE.
- out_cout = final carry_reg (for sub: 1 = no borrow). out_ovf = (A_msb==Beff_msb) & (sum_msb!=A_msb).
- in_valid outside IDLE ignored; input changes after accept have no effect.
- out_ready high before out_valid: no effect.
- WIDTH=32: single RUN beat; beat counter width max(1,$clog2(BEATS)).

## Timing
- Reset (rst sampled high): state IDLE, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0; in_ready=1 from the first cycle after rst deasserts (combinational from state).
- Accept edge = cycle 0. RUN cycles 1..BEATS. out_valid high from cycle BEATS+1.
- Output handshake at cycle k → in_ready high at k+1. Minimum issue interval BEATS+2.
- rst mid-RUN/DONE: operation abandoned, no out_valid, outputs cleared next edge.
- No combinational path in_* → out_*; in_ready depends only on state.

## Configuration
- WIDE_ADD_SUB_EN defined: in_sub honoured (B inverted, carry-in forced 1, in_cin ignored).
- Undefined: in_sub port present but ignored; always A+B+in_cin; inverter logic not built.

## Structure
- Package wide_add_pkg: SLICE_W=32 constant; state enum typedef {S_IDLE, S_RUN, S_DONE}.
- One sub-module: existing cla32 (cin/cout used; no other adders). Shift registers, counter, FSM in wide_add_seq.

## Test plan
- WIDTH=128, A=all-ones, B=1, cin=0 → out_sum=0, out_cout=1, out_ovf=0, out_valid exactly 5 cycles after accept.
- A=2^127−1, B=1 → out_sum=2^127, out_cout=0, out_ovf=1; A=B=2^127 → sum=0, cout=1, ovf=1.
- WIDE_ADD_SUB_EN: A=5, B=7, sub → sum=2^128−2, cout=0; A=7, B=5, sub → sum=2, cout=1; undefined build with sub=1: A=7, B=5 → 12.
- Backpressure: out_ready low 10 cycles → out_valid/out_sum stable, in_ready=0, in_valid pulses ignored; handshake → in_ready=1 next cycle.
- rst pulsed at RUN beat 2 → no out_valid, outputs 0, busy=0; new op afterward gives correct result.
- Randomized back-to-back ops with random out_ready, WIDTH=32 and 128, vs behavioural model.
